// File: rtl/freq_duty_meter_top.sv
// freq_duty_meter_top: measures frequency (Hz) and duty (%) of signal_in over a 1 s gate
// and scans the results onto an 8-digit 7-segment display through two daisy-chained 74HC595s.
// Ports: clk        - system clock, all logic on the rising edge
//        rst_n      - asynchronous reset, active HIGH despite the name
//        signal_in  - asynchronous input under measurement
//        rclk       - 595 storage/latch clock
//        sclk       - 595 shift clock
//        dio        - 595 serial data, MSB first
module freq_duty_meter_top #(
  parameter int CLK_FREQ = 50000000,
  parameter int SCLK_DIV = 25,
  parameter int MAX_FREQ = 9999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_in,
  output logic rclk,
  output logic sclk,
  output logic dio
);
  localparam int GW   = $clog2(CLK_FREQ);
  localparam int DDIV = CLK_FREQ / 100;
  localparam int HW   = (DDIV > 1) ? $clog2(DDIV) : 1;
  localparam int DW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, SHIFT_LOW, SHIFT_HIGH, LATCH_HIGH, LATCH_LOW
  } state_t;

  logic          r_s1, r_s2, r_s3;
  logic [GW-1:0] r_gate;
  logic [13:0]   r_edge, r_freq, w_edge_nxt;
  logic [HW-1:0] r_hsub;
  logic [6:0]    r_duty_cnt, r_duty, w_duty_nxt;
  logic          w_gate_end, w_rise, w_dinc;

  assign w_gate_end = (r_gate == GW'(CLK_FREQ - 1));
  assign w_rise     = r_s2 & ~r_s3;
  assign w_dinc     = r_s2 & (r_hsub == HW'(DDIV - 1));
  assign w_edge_nxt = (w_rise && r_edge < 14'(MAX_FREQ))
                    ? r_edge + 14'd1 : r_edge;
  assign w_duty_nxt = (w_dinc && r_duty_cnt != 7'd100)
                    ? r_duty_cnt + 7'd1 : r_duty_cnt;

  // r_s1/r_s2 synchronize, r_s3 is the previous sample for edge detection
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      {r_s1, r_s2, r_s3} <= '0;
    end else begin
      {r_s1, r_s2, r_s3} <= {signal_in, r_s1, r_s2};
    end
  end

  // gate end captures counts including the event of that same cycle
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_gate     <= '0;
      r_edge     <= '0;
      r_hsub     <= '0;
      r_duty_cnt <= '0;
      r_freq     <= '0;
      r_duty     <= '0;
    end else begin
      r_gate <= w_gate_end ? '0 : r_gate + GW'(1);
      if (w_gate_end) begin
        r_freq     <= w_edge_nxt;
        r_duty     <= w_duty_nxt;
        r_edge     <= '0;
        r_hsub     <= '0;
        r_duty_cnt <= '0;
      end else begin
        r_edge     <= w_edge_nxt;
        r_duty_cnt <= w_duty_nxt;
        if (r_s2) begin
          r_hsub <= w_dinc ? '0 : r_hsub + HW'(1);
        end
      end
    end
  end

  function automatic logic [15:0] f_bcd(input logic [13:0] bin);
    logic [15:0] b;
    b = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++) begin
        if (b[4*j +: 4] > 4'd4) b[4*j +: 4] = b[4*j +: 4] + 4'd3;
      end
      b = {b[14:0], bin[i]};
    end
    return b;
  endfunction

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  logic [15:0] w_fbcd;
  logic [11:0] w_dbcd;
  logic [3:0]  w_dig;
  logic [7:0]  w_seg;
  logic [2:0]  r_idx, w_idx;

  assign w_fbcd = f_bcd(r_freq);
  assign w_dbcd = 12'(f_bcd({7'd0, r_duty}));

  // code 4'hF renders as blank
  always_comb begin
    w_dig = 4'hF;
    case (r_idx)
      3'd7:    w_dig = w_fbcd[15:12];
      3'd6:    w_dig = w_fbcd[11:8];
      3'd5:    w_dig = w_fbcd[7:4];
      3'd4:    w_dig = w_fbcd[3:0];
      3'd2:    w_dig = w_dbcd[11:8];
      3'd1:    w_dig = w_dbcd[7:4];
      3'd0:    w_dig = w_dbcd[3:0];
      default: w_dig = 4'hF;
    endcase
  end

  assign w_seg = f_seg(w_dig);

  state_t        r_state, w_state;
  logic [DW-1:0] r_div, w_div;
  logic [3:0]    r_bit, w_bit;
  logic [15:0]   r_frame, w_frame;
  logic          r_sclk, r_rclk, r_dio;
  logic          w_sclk, w_rclk, w_dio;
  logic          w_div_end;

  assign w_div_end = (r_div == DW'(SCLK_DIV - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_frame <= '0;
      r_idx   <= '0;
      r_sclk  <= 1'b0;
      r_rclk  <= 1'b0;
      r_dio   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_frame <= w_frame;
      r_idx   <= w_idx;
      r_sclk  <= w_sclk;
      r_rclk  <= w_rclk;
      r_dio   <= w_dio;
    end
  end

  // IDLE is the one-cycle load slot and also the last rclk-low cycle,
  // so LATCH_LOW runs SCLK_DIV-1 cycles and a frame is 34*SCLK_DIV
  always_comb begin
    w_state = r_state;
    w_div   = r_div + DW'(1);
    w_bit   = r_bit;
    w_frame = r_frame;
    w_idx   = r_idx;
    w_sclk  = r_sclk;
    w_rclk  = r_rclk;
    w_dio   = r_dio;
    case (r_state)
      IDLE: begin
        w_frame = {w_seg, 8'b1 << r_idx};
        w_dio   = w_seg[7];
        w_bit   = 4'd15;
        w_div   = '0;
        w_sclk  = 1'b0;
        w_rclk  = 1'b0;
        w_state = SHIFT_LOW;
      end
      SHIFT_LOW: begin
        if (w_div_end) begin
          w_div   = '0;
          w_sclk  = 1'b1;
          w_state = SHIFT_HIGH;
        end
      end
      SHIFT_HIGH: begin
        if (w_div_end) begin
          w_div  = '0;
          w_sclk = 1'b0;
          if (r_bit == 4'd0) begin
            w_rclk  = 1'b1;
            w_state = LATCH_HIGH;
          end else begin
            w_bit   = r_bit - 4'd1;
            w_frame = {r_frame[14:0], 1'b0};
            w_dio   = r_frame[14];
            w_state = SHIFT_LOW;
          end
        end
      end
      LATCH_HIGH: begin
        if (w_div_end) begin
          w_div   = '0;
          w_rclk  = 1'b0;
          w_state = LATCH_LOW;
        end
      end
      LATCH_LOW: begin
        if (r_div == DW'(SCLK_DIV - 2)) begin
          w_div   = '0;
          w_idx   = r_idx + 3'd1;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign rclk = r_rclk;
  assign sclk = r_sclk;
  assign dio  = r_dio;
endmodule

// File: tb/tb_freq_duty_meter_top.sv
// tb_freq_duty_meter_top: directed bench decoding the 595 serial stream
// of two meter instances (small gate, and a larger gate for saturation).
module tb_freq_duty_meter_top;
  localparam int CF  = 1000;
  localparam int CF2 = 24000;
  localparam int SD  = 2;
  localparam int FRM = 34 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic sig = 1'b0;
  logic sig2 = 1'b0;
  logic rclk, sclk, dio;
  logic rclk2, sclk2, dio2;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  freq_duty_meter_top #(
    .CLK_FREQ(CF), .SCLK_DIV(SD), .MAX_FREQ(9999)
  ) dut (
    .clk(clk), .rst_n(rst), .signal_in(sig),
    .rclk(rclk), .sclk(sclk), .dio(dio)
  );

  freq_duty_meter_top #(
    .CLK_FREQ(CF2), .SCLK_DIV(SD), .MAX_FREQ(9999)
  ) dut2 (
    .clk(clk), .rst_n(rst2), .signal_in(sig2),
    .rclk(rclk2), .sclk(sclk2), .dio(dio2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int per = 1000;
  int hi = 0;
  int ph = 0;

  initial forever begin
    @(negedge clk);
    sig = (ph < hi);
    ph = (ph >= per - 1) ? 0 : ph + 1;
  end

  initial forever begin
    @(negedge clk);
    if (!rst2) sig2 = ~sig2;
  end

  int cyc = 0;
  logic [7:0] disp [8];
  logic [7:0] disp2 [8];
  logic p_s = 0, p_r = 0, p_d = 0;
  logic [15:0] sh = 0;
  logic [15:0] first_fr = 0;
  logic first_ok = 0;
  int nr = 0, t_rclk = -1, t_rise = -1, t_dio = 0;
  int per_min = 9999, per_max = 0, su_min = 9999;
  int nr_min = 9999, nr_max = 0, rw_min = 9999, rw_max = 0;
  int fp_min = 9999, fp_max = 0, sel_bad = 0;
  logic p_s2 = 0, p_r2 = 0;
  logic [15:0] sh2 = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      p_s = 0; p_r = 0; p_d = 0; nr = 0;
      t_rclk = -1; t_rise = -1; t_dio = cyc;
      first_ok = 0; first_fr = 0;
    end else begin
      if (dio !== p_d) t_dio = cyc;
      if (sclk && !p_s) begin
        sh = {sh[14:0], dio};
        if (nr > 0) begin
          if (cyc - t_rise < per_min) per_min = cyc - t_rise;
          if (cyc - t_rise > per_max) per_max = cyc - t_rise;
        end
        if (cyc - t_dio < su_min) su_min = cyc - t_dio;
        nr++;
        t_rise = cyc;
      end
      if (rclk && !p_r) begin
        if (nr < nr_min) nr_min = nr;
        if (nr > nr_max) nr_max = nr;
        nr = 0;
        if (t_rclk >= 0) begin
          if (cyc - t_rclk < fp_min) fp_min = cyc - t_rclk;
          if (cyc - t_rclk > fp_max) fp_max = cyc - t_rclk;
        end
        t_rclk = cyc;
        if ($countones(sh[7:0]) != 1) sel_bad++;
        else for (int i = 0; i < 8; i++) if (sh[i]) disp[i] = sh[15:8];
        if (!first_ok) begin
          first_fr = sh;
          first_ok = 1;
        end
      end
      if (!rclk && p_r) begin
        if (cyc - t_rclk < rw_min) rw_min = cyc - t_rclk;
        if (cyc - t_rclk > rw_max) rw_max = cyc - t_rclk;
      end
      p_s = sclk; p_r = rclk; p_d = dio;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst2) begin
      if (sclk2 && !p_s2) sh2 = {sh2[14:0], dio2};
      if (rclk2 && !p_r2) begin
        for (int i = 0; i < 8; i++) if (sh2[i]) disp2[i] = sh2[15:8];
      end
      p_s2 = sclk2; p_r2 = rclk2;
    end
  end

  task automatic chk_disp(input string tag, input logic [63:0] exp,
                          input bit second);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_d%0d", tag, i),
          second ? disp2[i] : disp[i], exp[8*i +: 8]);
    end
  endtask

  task automatic clr_disp();
    for (int i = 0; i < 8; i++) disp[i] = 8'h00;
  endtask

  task automatic run_case(input string tag, input int p, input int h,
                          input logic [63:0] exp);
    per = p; hi = h; ph = 0;
    repeat (2 * CF + 100) @(negedge clk);
    clr_disp();
    repeat (8 * FRM + 100) @(negedge clk);
    chk_disp(tag, exp, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      disp[i] = 8'h00;
      disp2[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_rclk", rclk, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_dio", dio, 0);
    rst = 0;
    rst2 = 0;
    repeat (200) @(negedge clk);
    chk("first_frame", first_fr, 16'hC001);

    run_case("hz1_d50", 1000, 500, 64'hC0C0C0F9_FFC092C0);
    run_case("hz10_d70", 100, 70, 64'hC0C0F9C0_FFC0F8C0);
    run_case("hz20_d30", 50, 15, 64'hC0C0A4C0_FFC0B0C0);
    run_case("const_hi", 1000, 1000, 64'hC0C0C0C0_FFF9C0C0);

    begin
      int k;
      k = 0;
      while (!sclk && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("pre_rst_sclk", sclk, 1);
    #2 rst = 1;
    #1;
    chk("arst_rclk", rclk, 0);
    chk("arst_sclk", sclk, 0);
    chk("arst_dio", dio, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    clr_disp();
    repeat (8 * FRM + 100) @(negedge clk);
    chk("post_rst_first", first_fr, 16'hC001);
    chk_disp("post_rst", 64'hC0C0C0C0_FFC0C0C0, 0);

    run_case("const_lo", 1000, 0, 64'hC0C0C0C0_FFC0C0C0);

    chk("sclk_per_min", per_min, 2 * SD);
    chk("sclk_per_max", per_max, 2 * SD);
    chk("dio_setup", su_min >= SD, 1);
    chk("rises_min", nr_min, 16);
    chk("rises_max", nr_max, 16);
    chk("rclk_w_min", rw_min, SD);
    chk("rclk_w_max", rw_max, SD);
    chk("frame_min", fp_min, FRM);
    chk("frame_max", fp_max, FRM);
    chk("sel_onehot", sel_bad, 0);

    while (cyc < 2 * CF2 + 150) @(negedge clk);
    for (int i = 0; i < 8; i++) disp2[i] = 8'h00;
    repeat (8 * FRM + 100) @(negedge clk);
    chk_disp("sat", 64'h90909090_FFC092C0, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
